s_mac_fxp: RTL and testbench
============================

# s_mac_fxp

Parametrised, pipelined signed fixed-point multiply-accumulate unit. It is the registered, streaming successor to the combinational signed adder/multiplier pair:
- multiplies each valid input pair;
- accumulates exactly `ACC_LEN` products per frame;
- rounds and saturates the frame sum to `OUTWL` bits;
- emits a one-cycle result pulse.

It sits in the datapath between a sample source and a fixed-point consumer such as a filter tap or correlator stage.

## Interface
- `IN1WL`, 8, signed word length of `I_IN1`
- `IN2WL`, 8, signed word length of `I_IN2`
- `ACC_LEN`, 16, products per frame; ≥ 1
- `ACC_GUARD`, 4, accumulator guard bits; must satisfy `2^ACC_GUARD ≥ ACC_LEN`
- `OUT_SHIFT`, 7, LSBs dropped from the sum (output FWL = FWL1 + FWL2 − `OUT_SHIFT`); 0 disables rounding
- `OUTWL`, 8, signed word length of `O_OUT`
- `I_CLK`  in  1  clock; all logic on the rising edge
- `I_RSTN`  in  1  reset; asynchronous, active-low
- `I_VALID`  in  1  `I_IN1`/`I_IN2` carry a sample this cycle
- `I_IN1`  in  `IN1WL`  signed operand 1
- `I_IN2`  in  `IN2WL`  signed operand 2
- `I_CLR`  in  1  synchronous frame restart
- `O_VALID`  out  1  one-cycle pulse: `O_OUT` holds a new frame result
- `O_OUT`  out  `OUTWL`  signed rounded, saturated frame sum
- `O_OVF`  out  1  the result in `O_OUT` was saturated

## Operation
- **Accumulator width:** `ACCWL = IN1WL + IN2WL + ACC_GUARD`. With the guard rule met, the accumulator never wraps.
- **Stage 1 (multiply):** on each accepted sample (`I_VALID = 1`), register the full-precision `IN1WL + IN2WL` signed product and a valid bit.
- **Stage 2 (accumulate):** frame counter runs 0..`ACC_LEN − 1`, counting valid stage-1 products.
  - Not the last product: accumulator += product; counter++.
  - Last product: register the frame sum (accumulator + product) with a done bit; reset accumulator and counter to 0.
  - `I_VALID` gaps: allowed anywhere; they stall the frame but do not end it.
- **Stage 3 (round/saturate):**
  - Rounding: add `1 << (OUT_SHIFT − 1)`, then arithmetic-shift right by `OUT_SHIFT`. This is round-half-up (toward +∞ at ties).
  - Saturation: clamp to [−2^(OUTWL−1), 2^(OUTWL−1) − 1]. `O_OVF = 1` iff clamped.
  - On done, register `O_OUT` and `O_OVF`, and pulse `O_VALID`. `O_OUT` and `O_OVF` hold until the next result.
- **`I_CLR` rules:**
  - Clears the accumulator, the counter and the stage-1 valid bit.
  - A stage-2 done already produced still completes through stage 3.
  - A sample with `I_VALID` in the same cycle as `I_CLR` is kept as product 0 of the new frame.
- **Degenerate case:** `ACC_LEN = 1` makes every product its own frame.
- **No backpressure:** the consumer must accept every `O_VALID` pulse.

## Timing
- **Reset (`I_RSTN` low, any time):** `O_VALID = 0`, `O_OUT = 0`, `O_OVF = 0`. All pipeline valid bits, the accumulator and the counter are 0. Any partial frame is discarded, and the first valid sample after release is product 0.
- **Latency:** the last sample of a frame is accepted on edge n; `O_VALID` is high for exactly the cycle following edge n+2.
- **Throughput:** one sample per cycle. Back-to-back frames give `O_VALID` pulses exactly `ACC_LEN` cycles apart.

## Structure
- Shared package `s_fxp_pkg`:
  - `clog2` function, used to size the counter;
  - `ACCWL` derivation;
  - elaboration check of the `ACC_GUARD` rule.
- Sub-module `s_round_sat` (parameters `INWL`, `SHIFT`, `OUTWL`): combinational round + saturate + overflow flag. It is reusable by later fixed-point blocks, and `s_mac_fxp` registers its outputs in stage 3.

## Test plan
Bench parameters for all scenarios: `IN1WL = IN2WL = OUTWL = 8`, `OUT_SHIFT = 7`, `ACC_LEN = 4`, `ACC_GUARD = 2`.
1. **Reset values:** hold `I_RSTN` low with random inputs → `O_VALID`, `O_OUT`, `O_OVF` all 0; after release, no `O_VALID` without 4 samples.
2. **Nominal and saturating sums:**
   - 4 × (32, 32) back-to-back → one pulse 3 cycles after the 4th sample, `O_OUT = 32`, `O_OVF = 0`.
   - 4 × (−128, −128) → `O_OUT = 127`, `O_OVF = 1`.
   - 4 × (127, −128) → `O_OUT = −128`, `O_OVF = 1`.
3. **Rounding at ties:** (1, 64) + 3 × (0, 0) → 1; (1, 63) + 3 zeros → 0; (−1, 64) + 3 zeros → 0; (−1, 65) + 3 zeros → −1.
4. **Gaps:** 4 × (32, 32) with `I_VALID` gaps of 0–3 cycles → single pulse, `O_OUT = 32`. Continuous 12 samples → pulses exactly 4 cycles apart.
5. **Clear mid-frame:** 2 × (64, 64), then `I_CLR` together with a valid (32, 32), then 3 × (32, 32) → one pulse, `O_OUT = 32`.
6. **Reset mid-frame:** `I_RSTN` low for 1 cycle after 2 samples → outputs return to 0; the next 4 × (32, 32) → `O_OUT = 32`.

Source files
------------

// File: rtl/s_fxp_pkg.sv
// Shared fixed-point helpers: counter sizing, accumulator width, guard rule.
package s_fxp_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_wl(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Accumulator width: full product plus guard bits.
  function automatic int acc_wl(input int in1wl, input int in2wl, input int guard);
    return in1wl + in2wl + guard;
  endfunction

  // True when the guard bits cover acc_len products without wrap.
  function automatic bit guard_ok(input int acc_len, input int guard);
    return (acc_len >= 1) && ((64'(1) << guard) >= 64'(acc_len));
  endfunction

endpackage

// File: rtl/s_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturate with overflow flag.
module s_round_sat #(
  parameter int INWL  = 18,
  parameter int SHIFT = 7,
  parameter int OUTWL = 8
) (
  input  logic [INWL-1:0]  in_i,
  output logic [OUTWL-1:0] out_o,
  output logic             ovf_o
);
  // One extra bit so adding the rounding half never wraps.
  localparam int RW = INWL + 1;
  localparam int CW = RW + OUTWL;
  localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] HALF = (SHIFT > 0) ? (RW'(1) << HS) : '0;
  localparam logic signed [CW-1:0] MAXV = (CW'(1) <<< (OUTWL - 1)) - CW'(1);
  localparam logic signed [CW-1:0] MINV = -(CW'(1) <<< (OUTWL - 1));

  logic signed [RW-1:0] rnd;
  logic signed [CW-1:0] shx;

  assign rnd = RW'($signed(in_i)) + HALF;
  assign shx = CW'(rnd >>> SHIFT);

  // Clamp the shifted value into the output range and flag any clamp.
  always_comb begin
    out_o = OUTWL'(shx);
    ovf_o = 1'b0;
    if (shx > MAXV) begin
      out_o = OUTWL'(MAXV);
      ovf_o = 1'b1;
    end else if (shx < MINV) begin
      out_o = OUTWL'(MINV);
      ovf_o = 1'b1;
    end
  end
endmodule

// File: rtl/s_mac_fxp.sv
// Three-stage signed fixed-point MAC: multiply, frame accumulate, round/saturate.
module s_mac_fxp
  import s_fxp_pkg::*;
#(
  parameter int IN1WL     = 8,
  parameter int IN2WL     = 8,
  parameter int ACC_LEN   = 16,
  parameter int ACC_GUARD = 4,
  parameter int OUT_SHIFT = 7,
  parameter int OUTWL     = 8
) (
  input  logic             I_CLK,
  input  logic             I_RSTN,
  input  logic             I_VALID,
  input  logic [IN1WL-1:0] I_IN1,
  input  logic [IN2WL-1:0] I_IN2,
  input  logic             I_CLR,
  output logic             O_VALID,
  output logic [OUTWL-1:0] O_OUT,
  output logic             O_OVF
);
  localparam int PW    = IN1WL + IN2WL;
  localparam int ACCWL = acc_wl(IN1WL, IN2WL, ACC_GUARD);
  localparam int CNTW  = cnt_wl(ACC_LEN);
  localparam logic [CNTW-1:0] LAST = CNTW'(ACC_LEN - 1);

  if (!guard_ok(ACC_LEN, ACC_GUARD)) begin : g_guard_chk
    $error("s_mac_fxp: ACC_LEN must be >= 1 and 2**ACC_GUARD >= ACC_LEN");
  end

  // vld_pipe_q[1]: stage-1 product valid, [2]: frame done, [3]: result pulse.
  logic [3:1]             vld_pipe_q;
  logic signed [PW-1:0]   prod_q;
  logic signed [ACCWL-1:0] acc_q, acc_d, sum_q, sum_d, sum_nxt;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   done_d;
  logic [OUTWL-1:0]       rs_out, out_q;
  logic                   rs_ovf, ovf_q;

  // Stage 1: register the full-precision product of each accepted sample.
  // A clear drops the product already in flight; a sample arriving with the
  // clear is kept as product 0 of the new frame.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      vld_pipe_q[1] <= 1'b0;
      prod_q        <= '0;
    end else begin
      vld_pipe_q[1] <= I_VALID;
      if (I_VALID) prod_q <= PW'($signed(I_IN1)) * PW'($signed(I_IN2));
    end
  end

  assign sum_nxt = acc_q + ACCWL'(prod_q);

  // Stage 2 next state: accumulate, close the frame on the last product.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    done_d = 1'b0;
    if (I_CLR) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (vld_pipe_q[1]) begin
      if (cnt_q == LAST) begin
        sum_d  = sum_nxt;
        done_d = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = sum_nxt;
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // Stage 2 state register.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      sum_q         <= '0;
      vld_pipe_q[2] <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      vld_pipe_q[2] <= done_d;
    end
  end

  s_round_sat #(
    .INWL (ACCWL),
    .SHIFT(OUT_SHIFT),
    .OUTWL(OUTWL)
  ) u_rs (
    .in_i (sum_q),
    .out_o(rs_out),
    .ovf_o(rs_ovf)
  );

  // Stage 3: capture the rounded result on done; it holds until the next one.
  // A done already in stage 2 completes here regardless of a clear.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      vld_pipe_q[3] <= 1'b0;
      out_q         <= '0;
      ovf_q         <= 1'b0;
    end else begin
      vld_pipe_q[3] <= vld_pipe_q[2];
      if (vld_pipe_q[2]) begin
        out_q <= rs_out;
        ovf_q <= rs_ovf;
      end
    end
  end

  assign O_VALID = vld_pipe_q[3];
  assign O_OUT   = out_q;
  assign O_OVF   = ovf_q;
endmodule

// File: tb/tb_s_mac_fxp.sv
// Self-checking bench for s_mac_fxp: frame table, random frames, clear/reset corners.
module tb_s_mac_fxp;
  localparam int ACC_LEN = 4;

  logic clk, rstn, vld, clr, o_vld, o_ovf;
  logic signed [7:0] a, b, o_out;

  s_mac_fxp #(
    .IN1WL(8), .IN2WL(8), .ACC_LEN(ACC_LEN), .ACC_GUARD(2), .OUT_SHIFT(7), .OUTWL(8)
  ) dut (
    .I_CLK(clk), .I_RSTN(rstn), .I_VALID(vld), .I_IN1(a), .I_IN2(b),
    .I_CLR(clr), .O_VALID(o_vld), .O_OUT(o_out), .O_OVF(o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int out; int ovf; longint due; } exp_t;
  exp_t sb[$];

  typedef struct {
    int a[4]; int b[4]; int gap[4]; int eout; int eovf;
  } vec_t;

  int n_cmp = 0, n_err = 0;
  int macc = 0, mcnt = 0;
  bit ov_en = 0;
  int ov_out = 0, ov_ovf = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference round-half-up / saturate on the frame sum (Q.14 -> Q.7).
  function automatic int ref_q(input int s);
    int t;
    t = s + 64;
    return (t >= 0) ? t / 128 : -((-t + 127) / 128);
  endfunction
  function automatic int ref_out(input int s);
    int q;
    q = ref_q(s);
    return (q > 127) ? 127 : (q < -128) ? -128 : q;
  endfunction
  function automatic int ref_ovf(input int s);
    return (ref_q(s) > 127 || ref_q(s) < -128) ? 1 : 0;
  endfunction

  // Scoreboard consumer: every pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rstn && o_vld) begin
      if (sb.size() == 0) chk("spurious_pulse", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out", int'(o_out), e.out);
        chk("ovf", int'(o_ovf), e.ovf);
        chk("latency", int'(cyc), int'(e.due));
      end
    end
  end

  task automatic samp(input int x, input int y, input bit c);
    exp_t e;
    @(posedge clk); #1;
    vld = 1'b1; a = x[7:0]; b = y[7:0]; clr = c;
    if (c) begin macc = 0; mcnt = 0; end
    macc += x * y;
    mcnt++;
    if (mcnt == ACC_LEN) begin
      e.out = ov_en ? ov_out : ref_out(macc);
      e.ovf = ov_en ? ov_ovf : ref_ovf(macc);
      e.due = cyc + 3;
      sb.push_back(e);
      macc = 0; mcnt = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vld = 1'b0; clr = 1'b0; a = 8'($urandom); b = 8'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{a:'{32,32,32,32},     b:'{32,32,32,32},         gap:'{0,0,0,0}, eout:32,   eovf:0};
    tbl[1] = '{a:'{-128,-128,-128,-128}, b:'{-128,-128,-128,-128}, gap:'{0,0,0,0}, eout:127, eovf:1};
    tbl[2] = '{a:'{127,127,127,127}, b:'{-128,-128,-128,-128}, gap:'{0,0,0,0}, eout:-128, eovf:1};
    tbl[3] = '{a:'{1,0,0,0},         b:'{64,0,0,0},            gap:'{0,0,0,0}, eout:1,    eovf:0};
    tbl[4] = '{a:'{1,0,0,0},         b:'{63,0,0,0},            gap:'{0,0,0,0}, eout:0,    eovf:0};
    tbl[5] = '{a:'{-1,0,0,0},        b:'{64,0,0,0},            gap:'{0,0,0,0}, eout:0,    eovf:0};
    tbl[6] = '{a:'{-1,0,0,0},        b:'{65,0,0,0},            gap:'{0,0,0,0}, eout:-1,   eovf:0};
    tbl[7] = '{a:'{32,32,32,32},     b:'{32,32,32,32},         gap:'{1,3,0,2}, eout:32,   eovf:0};

    // Reset held with random inputs: outputs stay 0.
    rstn = 1'b0; vld = 1'b0; clr = 1'b0; a = '0; b = '0;
    for (int i = 0; i < 4; i++) begin
      vld = 1'($urandom); clr = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk("rst_valid", int'(o_vld), 0);
      chk("rst_out", int'(o_out), 0);
      chk("rst_ovf", int'(o_ovf), 0);
    end
    vld = 1'b0; clr = 1'b0;
    rstn = 1'b1;

    // Three samples alone must not produce a pulse; then restart the frame.
    samp(5, 7, 0); samp(-3, 9, 0); samp(100, 100, 0);
    idle(6);
    @(posedge clk); #1; vld = 1'b0; clr = 1'b1; macc = 0; mcnt = 0;
    idle(2);

    // Table frames, back-to-back except where gaps are listed.
    for (int r = 0; r < 8; r++) begin
      ov_en = 1; ov_out = tbl[r].eout; ov_ovf = tbl[r].eovf;
      for (int s = 0; s < 4; s++) begin
        idle(tbl[r].gap[s]);
        samp(tbl[r].a[s], tbl[r].b[s], 0);
      end
    end
    ov_en = 0;
    idle(1);
    drain();

    // Result holds between pulses.
    idle(5);
    @(negedge clk);
    chk("hold_out", int'(o_out), 32);
    chk("hold_valid", int'(o_vld), 0);

    // Twelve continuous random samples: three frames, pulses 4 cycles apart.
    for (int i = 0; i < 12; i++)
      samp(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 0);
    idle(1);
    drain();

    // Clear mid-frame: the two large products are discarded.
    ov_en = 1; ov_out = 32; ov_ovf = 0;
    samp(64, 64, 0); samp(64, 64, 0);
    samp(32, 32, 1);
    samp(32, 32, 0); samp(32, 32, 0); samp(32, 32, 0);
    ov_en = 0;
    idle(1);
    drain();

    // Reset mid-frame: outputs return to 0 and the partial frame is lost.
    samp(64, 64, 0); samp(64, 64, 0);
    @(posedge clk); #1; vld = 1'b0; rstn = 1'b0;
    @(negedge clk);
    chk("mrst_out", int'(o_out), 0);
    chk("mrst_ovf", int'(o_ovf), 0);
    chk("mrst_valid", int'(o_vld), 0);
    @(posedge clk); #1; rstn = 1'b1;
    macc = 0; mcnt = 0;
    ov_en = 1; ov_out = 32; ov_ovf = 0;
    for (int i = 0; i < 4; i++) samp(32, 32, 0);
    ov_en = 0;
    idle(1);
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
